lfsr_tap_finder: RTL and testbench
==================================

LFSR_TAP_FINDER -- requirements
Module: lfsr_tap_finder

Interface
REQ-001 SHALL have parameter W, 7, LFSR state width in bits (2..8).
REQ-002 SHALL have parameter NTAPS, 9, number of candidate tap patterns.
REQ-003 SHALL have parameter PRE, 4, number of preamble bytes checked (>=1).
REQ-004 SHALL have parameter PCHAR, 8'h20, plaintext preamble character.
REQ-005 SHALL have port Clk  input  1  clock; all state changes on posedge.
REQ-006 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port Start  input  1  begin search; sampled only in IDLE or DONE.
REQ-008 SHALL have port BaseAddr  input  8  data-memory address of first ciphertext byte.
REQ-009 SHALL have port CandTaps  input  NTAPS*W  flattened tap table; entry k at bits [k*W +: W].
REQ-010 SHALL have port MemAddr  output  8  read address to data memory.
REQ-011 SHALL have port MemData  input  8  combinational read data for MemAddr, same cycle.
REQ-012 SHALL have port Busy  output  1  high in any search state.
REQ-013 SHALL have port Done  output  1  level flag, high in DONE only.
REQ-014 SHALL have port Found  output  1  a candidate matched; valid while Done.
REQ-015 SHALL have port TapIdx  output  $clog2(NTAPS)  index of matching candidate.
REQ-016 SHALL have port TapOut  output  W  matching tap pattern.
REQ-017 SHALL have port Seed  output  W  recovered initial LFSR state.

Function
REQ-018 SHALL use LFSR step next = {s[W-2:0], ^(s & tap)}.
REQ-019 SHALL implement FSM states IDLE, SEED, CHECK, DONE.
REQ-020 SHALL move IDLE->SEED, or DONE->SEED, on the cycle Start=1; clear Done, Found, TapIdx, TapOut and Seed; set candidate k=0.
REQ-021 In SEED, SHALL drive MemAddr=BaseAddr, latch s=(MemData^PCHAR)[W-1:0] as seed, set byte index i=1; go to CHECK if PRE>1, else go to DONE with Found=1 and k.
REQ-022 In CHECK, SHALL drive MemAddr=BaseAddr+i (8-bit wrap) and compare (MemData^PCHAR)[W-1:0] with step(s, tap k).
REQ-023 On match in CHECK, SHALL set s=step(s); if i==PRE-1, go to DONE with Found=1, TapIdx=k, TapOut=tap k, Seed=latched seed; else i=i+1.
REQ-024 On mismatch in CHECK, SHALL abort candidate k early: if k<NTAPS-1, set k=k+1, re-enter SEED; else go to DONE with Found=0.
REQ-025 SHALL report the lowest-index candidate when several match.
REQ-026 SHALL take exactly PRE cycles from Start to Done for a candidate-0 match; each failed candidate adds 1 + (cycles spent in CHECK) cycles.
REQ-027 SHALL ignore Start while Busy.
REQ-028 SHALL hold the DONE outputs until the next Start or Reset.
REQ-029 SHALL drive MemAddr=BaseAddr in IDLE and DONE.

Reset
REQ-030 SHALL, while Reset=1, force IDLE with Busy=Done=Found=0 and TapIdx=TapOut=Seed=0, including mid-search; Reset SHALL win over a simultaneous Start.

Structure
REQ-031 SHALL place the FSM state enum and the default 9-entry 7-bit tap table constant in shared package lfsr_pkg.
REQ-032 SHALL instantiate one combinational sub-module, lfsr_step (W-parameterised state plus tap in, next state out), shared with the processor LFSR path.

Verification
REQ-033 SHALL cover: W=7, table {60,48,78,72,6A,69,5C,7E,7B}h, message encrypted with tap idx 3, seed 7'h01 -> Done, Found=1, TapIdx=3, TapOut=7'h72, Seed=7'h01.
REQ-034 SHALL cover: ciphertext matching tap idx 0 -> Done is high exactly PRE=4 cycles after the Start cycle.
REQ-035 SHALL cover: ciphertext that matches no candidate -> Done, Found=0, TapIdx=0, Busy low afterwards.
REQ-036 SHALL cover: Reset pulsed during CHECK of candidate 2, then Start -> IDLE outputs all 0, then a correct fresh result.
REQ-037 SHALL cover: BaseAddr=8'hFE, PRE=4 -> MemAddr sequence FE, FF, 00, 01, with the correct match.
REQ-038 SHALL cover: Start re-asserted while Busy -> ignored, with the result identical to an undisturbed run.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: the tap-finder FSM states and the default tap table
// used by both the tap finder and the processor LFSR path.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } lfsr_state_e;

  localparam int DEF_W     = 7;
  localparam int DEF_NTAPS = 9;

  // Entry k lives at bits [k*7 +: 7], so entry 0 (7'h60) sits at the LSB end.
  localparam logic [DEF_NTAPS*DEF_W-1:0] DEF_TAPS = {
    7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
  };

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step: shift left and feed back the parity of the tapped bits.
module lfsr_step #(
  parameter int W = 7
) (
  input  logic [W-1:0] State,
  input  logic [W-1:0] Tap,
  output logic [W-1:0] Next
);

  assign Next = {State[W-2:0], ^(State & Tap)};

endmodule

// File: rtl/lfsr_tap_finder.sv
// Known-plaintext search: finds the lowest-index candidate tap whose keystream turns
// the ciphertext preamble into PCHAR bytes, and reports that tap and the seed.
module lfsr_tap_finder
  import lfsr_pkg::*;
#(
  parameter int         W     = 7,
  parameter int         NTAPS = 9,
  parameter int         PRE   = 4,
  parameter logic [7:0] PCHAR = 8'h20
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [7:0]                 BaseAddr,
  input  logic [NTAPS*W-1:0]         CandTaps,
  output logic [7:0]                 MemAddr,
  input  logic [7:0]                 MemData,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Found,
  output logic [$clog2(NTAPS)-1:0]   TapIdx,
  output logic [W-1:0]               TapOut,
  output logic [W-1:0]               Seed,
  output lfsr_state_e                DbgState
);

  localparam int KW = $clog2(NTAPS);
  localparam int IW = $clog2(PRE + 1);

  lfsr_state_e   state;
  logic [KW-1:0] k;
  logic [IW-1:0] i;
  logic [W-1:0]  s;
  logic [W-1:0]  seedReg;
  logic [W-1:0]  tapK;
  logic [W-1:0]  stepNext;
  logic [W-1:0]  plainW;

  // Only the low W plaintext bits carry keystream; the rest are deliberately ignored.
  generate
    if (W < 8) begin : gUnused
      logic unusedMemBits;
      assign unusedMemBits = ^MemData[7:W];
    end
  endgenerate

  assign plainW   = MemData[W-1:0] ^ PCHAR[W-1:0];
  assign tapK     = CandTaps[k*W +: W];
  assign MemAddr  = (state == CHECK) ? BaseAddr + 8'(i) : BaseAddr;
  assign DbgState = state;

  lfsr_step #(.W(W)) uStep (
    .State (s),
    .Tap   (tapK),
    .Next  (stepNext)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Found   <= 1'b0;
      TapIdx  <= '0;
      TapOut  <= '0;
      Seed    <= '0;
      k       <= '0;
      i       <= '0;
      s       <= '0;
      seedReg <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (Start) begin
            state  <= SEED;
            Busy   <= 1'b1;
            Done   <= 1'b0;
            Found  <= 1'b0;
            TapIdx <= '0;
            TapOut <= '0;
            Seed   <= '0;
            k      <= '0;
          end
        end
        SEED: begin
          s       <= plainW;
          seedReg <= plainW;
          i       <= IW'(1);
          if (PRE > 1) begin
            state <= CHECK;
          end else begin
            state  <= DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            Found  <= 1'b1;
            TapIdx <= k;
            TapOut <= tapK;
            Seed   <= plainW;
          end
        end
        CHECK: begin
          if (plainW == stepNext) begin
            s <= stepNext;
            if (i == IW'(PRE - 1)) begin
              state  <= DONE;
              Busy   <= 1'b0;
              Done   <= 1'b1;
              Found  <= 1'b1;
              TapIdx <= k;
              TapOut <= tapK;
              Seed   <= seedReg;
            end else begin
              i <= i + 1'b1;
            end
          end else if (k < KW'(NTAPS - 1)) begin
            // First wrong byte abandons this candidate; re-read the seed for the next one.
            k     <= k + 1'b1;
            state <= SEED;
          end else begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Found <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_tap_finder.sv
// Bench for lfsr_tap_finder: directed scenarios plus random trials against a
// candidate-by-candidate keystream model of the known-plaintext search.
module tb_lfsr_tap_finder;
  import lfsr_pkg::*;

  localparam int         WW    = 7;
  localparam int         NT    = 9;
  localparam int         PRE_N = 4;
  localparam logic [7:0] PCH   = 8'h20;
  localparam int         MASK  = (1 << WW) - 1;
  localparam int         TIMEOUT = 500;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        base_addr;
  logic [NT*WW-1:0]  cand_taps;
  logic [7:0]        mem_addr;
  logic [7:0]        mem_data;
  logic              busy, done, found;
  logic [3:0]        tap_idx;
  logic [WW-1:0]     tap_out, seed;
  lfsr_state_e       dbg_state;

  logic [7:0] mem [256];

  always #5 clk = ~clk;
  always_comb mem_data = mem[mem_addr];

  lfsr_tap_finder #(.W(WW), .NTAPS(NT), .PRE(PRE_N), .PCHAR(PCH)) dut (
    .Clk      (clk),
    .Reset    (reset),
    .Start    (start),
    .BaseAddr (base_addr),
    .CandTaps (cand_taps),
    .MemAddr  (mem_addr),
    .MemData  (mem_data),
    .Busy     (busy),
    .Done     (done),
    .Found    (found),
    .TapIdx   (tap_idx),
    .TapOut   (tap_out),
    .Seed     (seed),
    .DbgState (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] addr_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_step(input int s, input int t);
    return ((s * 2) & MASK) | ($countones(s & t) % 2);
  endfunction

  function automatic int tap_of(input logic [NT*WW-1:0] taps, input int k);
    return int'((taps >> (k * WW)) & MASK);
  endfunction

  // Tries each candidate in order, counting one cycle per memory byte examined.
  task automatic model_search(input logic [7:0] base, input logic [NT*WW-1:0] taps,
                              output bit f, output int idx, output int tapv,
                              output int seedv, output int cyc);
    int s, s0, t;
    bit ok;
    f = 0; idx = 0; tapv = 0; seedv = 0; cyc = 0;
    for (int k = 0; k < NT; k++) begin
      t   = tap_of(taps, k);
      s0  = int'(mem[base] ^ PCH) & MASK;
      s   = s0;
      cyc += 1;
      ok  = 1;
      for (int j = 1; j < PRE_N; j++) begin
        s = model_step(s, t);
        cyc += 1;
        if (s != (int'(mem[8'(int'(base) + j)] ^ PCH) & MASK)) begin
          ok = 0;
          break;
        end
      end
      if (ok) begin
        f = 1; idx = k; tapv = t; seedv = s0;
        return;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_random();
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
  endtask

  task automatic encrypt(input logic [7:0] base, input int t, input int sd);
    int s;
    s = sd;
    for (int j = 0; j < PRE_N; j++) begin
      mem[8'(int'(base) + j)] = PCH ^ 8'((int'($urandom_range(0, 1)) << 7) | s);
      s = model_step(s, t);
    end
  endtask

  // Pulses Start, then waits for Done; poke>=0 re-asserts Start at that cycle.
  task automatic run_search(input int poke, output int cyc, output bit to);
    addr_log.delete();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; to = 0;
    while (!done) begin
      if (busy) addr_log.push_back(mem_addr);
      start = (cyc == poke);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc > TIMEOUT) begin
        to = 1;
        break;
      end
    end
  endtask

  task automatic run_and_compare(input string tag, input int poke);
    bit ef, to;
    int eidx, etap, eseed, ecyc, cyc;
    model_search(base_addr, cand_taps, ef, eidx, etap, eseed, ecyc);
    run_search(poke, cyc, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    check({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
    check({tag, "_found"}, 32'(found), 32'(ef));
    check({tag, "_idx"}, 32'(tap_idx), 32'(eidx));
    check({tag, "_tap"}, 32'(tap_out), 32'(etap));
    check({tag, "_seed"}, 32'(seed), 32'(eseed));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, {30'd0, done, busy}, 32'd2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_flags"}, {29'd0, busy, done, found}, 32'd0);
    check({tag, "_outs"}, {11'd0, tap_idx, tap_out, seed}, 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'(base_addr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, s1;
    reset = 1'b1; start = 1'b0; base_addr = 8'h10; cand_taps = DEF_TAPS;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Directed: tap index 3, seed 1 against the default table.
    encrypt(8'h10, 'h72, 1);
    run_and_compare("idx3", -1);
    check("idx3_const_idx", 32'(tap_idx), 32'd3);
    check("idx3_const_tap", 32'(tap_out), 32'h72);
    check("idx3_const_seed", 32'(seed), 32'h01);

    // Candidate 0 match: Done exactly PRE cycles after Start.
    base_addr = 8'h40;
    encrypt(8'h40, 'h60, 'h35);
    run_and_compare("idx0", -1);
    check("idx0_latency", 32'(addr_log.size()), 32'(PRE_N));

    // No candidate can match: bit 1 of the second state contradicts the shift.
    base_addr = 8'h80;
    s0 = 'h2B;
    s1 = ((s0 * 2) & MASK) ^ 'h02;
    mem[8'h80] = PCH ^ 8'(s0);
    mem[8'h81] = PCH ^ 8'(s1);
    run_and_compare("nomatch", -1);
    check("nomatch_busy", 32'(busy), 32'd0);
    check("nomatch_done", 32'(done), 32'd1);

    // Reset during CHECK of candidate 2, with Start asserted simultaneously.
    base_addr = 8'h10;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst_state", 32'(dbg_state), 32'(CHECK));
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    reset = 1'b0; start = 1'b0;
    run_and_compare("after_rst", -1);

    // Address wrap across 8'hFF.
    base_addr = 8'hFE;
    encrypt(8'hFE, 'h60, 'h11);
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_and_compare("wrap", -1);
    check("wrap_len", 32'(addr_log.size()), 32'(exp_q.size()));
    foreach (exp_q[n]) begin
      if (n < addr_log.size()) check("wrap_addr", 32'(addr_log[n]), 32'(exp_q[n]));
    end

    // Start re-asserted mid-search must not disturb the result or timing.
    base_addr = 8'h10;
    run_and_compare("restart_busy", 5);

    // Random trials: random table, base, seed and chosen candidate.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NT; k++) cand_taps[k*WW +: WW] = WW'($urandom_range(1, MASK));
      base_addr = 8'($urandom_range(0, 255));
      fill_random();
      if ($urandom_range(0, 3) != 0)
        encrypt(base_addr, tap_of(cand_taps, int'($urandom_range(0, NT - 1))),
                int'($urandom_range(1, MASK)));
      run_and_compare("rand", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
